// File: rtl/tick_pkg.sv
// Shared types and sizing helpers for the tick stretcher.
package tick_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HIGH,
    GAP
  } stretch_state_t;

  // Width of the shared phase counter: large enough for the longest phase, at least one bit.
  function automatic int unsigned cnt_width(input int unsigned high_cycles,
                                            input int unsigned gap_cycles);
    int unsigned m;
    m = 2;
    if (high_cycles > m) m = high_cycles;
    if (gap_cycles > m) m = gap_cycles;
    return $clog2(m);
  endfunction

endpackage

// File: rtl/cycle_counter.sv
// Loadable down-counter that holds at zero; times the HIGH and GAP phases in turn.
module cycle_counter #(
  parameter int unsigned WIDTH = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  output logic [WIDTH-1:0] value,
  output logic             zero
);

  logic [WIDTH-1:0] value_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      value_q <= '0;
    end else if (load) begin
      value_q <= load_val;
    end else if (en && (value_q != '0)) begin
      value_q <= value_q - 1'b1;
    end
  end

  assign value = value_q;
  assign zero  = (value_q == '0);

endmodule

// File: rtl/tick_stretcher.sv
// Stretches single-cycle ticks into fixed-width level pulses separated by a guaranteed low gap;
// ticks arriving mid-pulse are queued in a saturating counter or retrigger the pulse.
module tick_stretcher
  import tick_pkg::*;
#(
  parameter int unsigned HIGH_CYCLES = 4,
  parameter int unsigned GAP_CYCLES  = 2,
  parameter int unsigned PEND_W      = 4,
  parameter bit          RETRIGGER   = 1'b0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              tick,
  input  logic              clr_ovf,
  output logic              level,
  output logic              busy,
  output logic [PEND_W-1:0] pend_count,
  output logic              overflow
);

  localparam int unsigned CNT_W = cnt_width(HIGH_CYCLES, GAP_CYCLES);
  localparam int unsigned GAP_LOAD_INT = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
  localparam logic [CNT_W-1:0]  HIGH_LOAD = CNT_W'(HIGH_CYCLES - 1);
  localparam logic [CNT_W-1:0]  GAP_LOAD  = CNT_W'(GAP_LOAD_INT);
  localparam logic [PEND_W-1:0] PEND_MAX  = '1;

  stretch_state_t    state_q, state_d;
  logic [PEND_W-1:0] pend_q, pend_d;
  logic              level_q, busy_q, ovf_q, ovf_d;

  logic             cnt_load, cnt_zero;
  logic [CNT_W-1:0] cnt_load_val, cnt_value;

  logic retrig, high_end, finish, enqueue, ovf_set;

  cycle_counter #(
    .WIDTH(CNT_W)
  ) u_cycle_counter (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (cnt_load),
    .load_val(cnt_load_val),
    .en      (state_q != IDLE),
    .value   (cnt_value),
    .zero    (cnt_zero)
  );

  always_comb begin
    retrig   = RETRIGGER && tick && (state_q == HIGH);
    high_end = (state_q == HIGH) && cnt_zero && !retrig;
    // With no gap the end of HIGH takes the same dequeue decision as the end of GAP.
    finish   = (high_end && (GAP_CYCLES == 0)) || ((state_q == GAP) && cnt_zero);
    enqueue  = tick && (state_q != IDLE) && !retrig && !finish;

    state_d      = state_q;
    pend_d       = pend_q;
    cnt_load     = 1'b0;
    cnt_load_val = HIGH_LOAD;
    ovf_set      = 1'b0;

    if (((state_q == IDLE) && tick) || retrig) begin
      state_d  = HIGH;
      cnt_load = 1'b1;
    end else if (finish) begin
      if ((pend_q != '0) || tick) begin
        state_d  = HIGH;
        cnt_load = 1'b1;
      end else begin
        state_d = IDLE;
      end
      // A tick arriving with the dequeue replaces the consumed entry.
      if ((pend_q != '0) && !tick) pend_d = pend_q - 1'b1;
    end else if (high_end) begin
      state_d      = GAP;
      cnt_load     = 1'b1;
      cnt_load_val = GAP_LOAD;
    end

    if (enqueue) begin
      if (pend_q == PEND_MAX) ovf_set = 1'b1;
      else pend_d = pend_q + 1'b1;
    end

    if (ovf_set) ovf_d = 1'b1;
    else if (clr_ovf) ovf_d = 1'b0;
    else ovf_d = ovf_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      pend_q  <= '0;
      ovf_q   <= 1'b0;
      level_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
      level_q <= (state_d == HIGH);
      busy_q  <= (state_d != IDLE);
    end
  end

  // The shared counter never holds more than the load of the phase it is timing.
  assert property (@(posedge clk) disable iff (!reset_n)
                   (state_q == HIGH) |-> (cnt_value <= HIGH_LOAD));

  assign level      = level_q;
  assign busy       = busy_q;
  assign pend_count = pend_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_tick_stretcher.sv
// Bench for tick_stretcher: three configurations driven in lockstep, directed scenarios
// plus random ticks checked against a cycle-count reference model.
module tb_tick_stretcher;

  localparam int N    = 3;
  localparam int H    = 4;
  localparam int PMAX = 3;

  // Instance 0: default, 1: retrigger, 2: no gap.
  int g_cfg[N] = '{2, 2, 0};
  int r_cfg[N] = '{0, 1, 0};

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic tick = 1'b0;
  logic clr_ovf = 1'b0;

  logic       lvl[N];
  logic       bsy[N];
  logic       ovf[N];
  logic [1:0] pc[N];

  int errors = 0;
  int checks = 0;

  // Model: remaining high / gap cycles (including the current one), queue depth, sticky flag.
  int hi_left[N];
  int gap_left[N];
  int m_pend[N];
  bit m_ovf[N];

  always #5 clk = ~clk;

  tick_stretcher #(.HIGH_CYCLES(4), .GAP_CYCLES(2), .PEND_W(2), .RETRIGGER(1'b0)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .tick(tick), .clr_ovf(clr_ovf),
    .level(lvl[0]), .busy(bsy[0]), .pend_count(pc[0]), .overflow(ovf[0])
  );
  tick_stretcher #(.HIGH_CYCLES(4), .GAP_CYCLES(2), .PEND_W(2), .RETRIGGER(1'b1)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .tick(tick), .clr_ovf(clr_ovf),
    .level(lvl[1]), .busy(bsy[1]), .pend_count(pc[1]), .overflow(ovf[1])
  );
  tick_stretcher #(.HIGH_CYCLES(4), .GAP_CYCLES(0), .PEND_W(2), .RETRIGGER(1'b0)) u_dut2 (
    .clk(clk), .reset_n(reset_n), .tick(tick), .clr_ovf(clr_ovf),
    .level(lvl[2]), .busy(bsy[2]), .pend_count(pc[2]), .overflow(ovf[2])
  );

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      hi_left[i] = 0;
      gap_left[i] = 0;
      m_pend[i] = 0;
      m_ovf[i] = 1'b0;
    end
  endtask

  task automatic model_end(input int i, input bit t);
    if (m_pend[i] > 0) begin
      hi_left[i] = H;
      if (!t) m_pend[i] = m_pend[i] - 1;
    end else if (t) begin
      hi_left[i] = H;
    end
  endtask

  task automatic model_queue(input int i, output bit set);
    set = 1'b0;
    if (m_pend[i] == PMAX) set = 1'b1;
    else m_pend[i] = m_pend[i] + 1;
  endtask

  task automatic model_step(input bit t, input bit c);
    for (int i = 0; i < N; i++) begin
      bit set;
      set = 1'b0;
      if (hi_left[i] == 0 && gap_left[i] == 0) begin
        if (t) hi_left[i] = H;
      end else if (hi_left[i] > 0) begin
        if (r_cfg[i] == 1 && t) begin
          hi_left[i] = H;
        end else if (hi_left[i] == 1 && g_cfg[i] == 0) begin
          hi_left[i] = 0;
          model_end(i, t);
        end else begin
          if (t) model_queue(i, set);
          hi_left[i] = hi_left[i] - 1;
          if (hi_left[i] == 0) gap_left[i] = g_cfg[i];
        end
      end else begin
        if (gap_left[i] == 1) begin
          gap_left[i] = 0;
          model_end(i, t);
        end else begin
          if (t) model_queue(i, set);
          gap_left[i] = gap_left[i] - 1;
        end
      end
      if (set) m_ovf[i] = 1'b1;
      else if (c) m_ovf[i] = 1'b0;
    end
  endtask

  // Drive one cycle of inputs, advance the model at the edge, return at the falling edge.
  task automatic cycle(input bit t, input bit c);
    tick = t;
    clr_ovf = c;
    @(posedge clk);
    model_step(t, c);
    @(negedge clk);
  endtask

  task automatic drain();
    repeat (30) cycle(1'b0, 1'b1);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      checks++; if (lvl[i] !== 1'b0) begin errors++; $display("FAIL reset_level[%0d]: got %b want 0", i, lvl[i]); end
      checks++; if (bsy[i] !== 1'b0) begin errors++; $display("FAIL reset_busy[%0d]: got %b want 0", i, bsy[i]); end
      checks++; if (pc[i] !== 2'd0) begin errors++; $display("FAIL reset_pend[%0d]: got %0d want 0", i, pc[i]); end
      checks++; if (ovf[i] !== 1'b0) begin errors++; $display("FAIL reset_ovf[%0d]: got %b want 0", i, ovf[i]); end
    end
    reset_n = 1'b1;
    repeat (3) cycle(1'b0, 1'b0);
  endtask

  task automatic test_single();
    for (int j = 0; j < 8; j++) begin
      cycle(j == 0, 1'b0);
      checks++; if (lvl[0] !== (j <= 3)) begin errors++; $display("FAIL single_level j=%0d: got %b want %b", j, lvl[0], (j <= 3)); end
      checks++; if (bsy[0] !== (j <= 5)) begin errors++; $display("FAIL single_busy j=%0d: got %b want %b", j, bsy[0], (j <= 5)); end
      checks++; if (bsy[2] !== (j <= 3)) begin errors++; $display("FAIL single_busy_gap0 j=%0d: got %b want %b", j, bsy[2], (j <= 3)); end
    end
  endtask

  task automatic test_queue();
    int maxp;
    maxp = 0;
    for (int j = 0; j < 20; j++) begin
      bit exp_l;
      cycle(j == 0 || j == 2 || j == 3, 1'b0);
      exp_l = (j <= 3) || (j >= 6 && j <= 9) || (j >= 12 && j <= 15);
      if (int'(pc[0]) > maxp) maxp = int'(pc[0]);
      checks++; if (lvl[0] !== exp_l) begin errors++; $display("FAIL queue_level j=%0d: got %b want %b", j, lvl[0], exp_l); end
    end
    checks++; if (maxp != 2) begin errors++; $display("FAIL queue_max_pend: got %0d want 2", maxp); end
    checks++; if (pc[0] !== 2'd0) begin errors++; $display("FAIL queue_end_pend: got %0d want 0", pc[0]); end
    checks++; if (bsy[0] !== 1'b0) begin errors++; $display("FAIL queue_end_busy: got %b want 0", bsy[0]); end
  endtask

  task automatic test_saturate();
    for (int j = 0; j < 27; j++) begin
      cycle(j <= 5, j == 20);
      if (j == 4) begin
        checks++; if (pc[0] !== 2'd3) begin errors++; $display("FAIL sat_pend: got %0d want 3", pc[0]); end
      end
      if (j == 5) begin
        checks++; if (ovf[0] !== 1'b1) begin errors++; $display("FAIL sat_ovf_set: got %b want 1", ovf[0]); end
        checks++; if (pc[1] !== 2'd0) begin errors++; $display("FAIL sat_rt_pend: got %0d want 0", pc[1]); end
        checks++; if (ovf[1] !== 1'b0) begin errors++; $display("FAIL sat_rt_ovf: got %b want 0", ovf[1]); end
      end
      if (j == 8) begin
        checks++; if (lvl[1] !== 1'b1) begin errors++; $display("FAIL sat_rt_level_hi: got %b want 1", lvl[1]); end
      end
      if (j == 9) begin
        checks++; if (lvl[1] !== 1'b0) begin errors++; $display("FAIL sat_rt_level_lo: got %b want 0", lvl[1]); end
      end
      if (j == 19) begin
        checks++; if (ovf[0] !== 1'b1) begin errors++; $display("FAIL sat_ovf_sticky: got %b want 1", ovf[0]); end
      end
      if (j == 20) begin
        checks++; if (ovf[0] !== 1'b0) begin errors++; $display("FAIL sat_ovf_clr: got %b want 0", ovf[0]); end
      end
    end
    checks++; if (bsy[0] !== 1'b0) begin errors++; $display("FAIL sat_drained_busy: got %b want 0", bsy[0]); end
  endtask

  task automatic test_retrigger();
    for (int j = 0; j < 13; j++) begin
      cycle(j == 0 || j == 3, 1'b0);
      checks++; if (lvl[1] !== (j <= 6)) begin errors++; $display("FAIL retrig_level j=%0d: got %b want %b", j, lvl[1], (j <= 6)); end
      checks++; if (pc[1] !== 2'd0) begin errors++; $display("FAIL retrig_pend j=%0d: got %0d want 0", j, pc[1]); end
    end
  endtask

  task automatic test_gap0();
    for (int j = 0; j < 11; j++) begin
      cycle(j <= 1, 1'b0);
      checks++; if (lvl[2] !== (j <= 7)) begin errors++; $display("FAIL gap0_level j=%0d: got %b want %b", j, lvl[2], (j <= 7)); end
    end
    checks++; if (pc[2] !== 2'd0) begin errors++; $display("FAIL gap0_pend: got %0d want 0", pc[2]); end
  endtask

  task automatic test_async_reset();
    cycle(1'b1, 1'b0);
    cycle(1'b1, 1'b0);
    checks++; if (lvl[0] !== 1'b1) begin errors++; $display("FAIL areset_pre_level: got %b want 1", lvl[0]); end
    checks++; if (pc[0] !== 2'd1) begin errors++; $display("FAIL areset_pre_pend: got %0d want 1", pc[0]); end
    tick = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    for (int i = 0; i < N; i++) begin
      checks++; if (lvl[i] !== 1'b0) begin errors++; $display("FAIL areset_level[%0d]: got %b want 0", i, lvl[i]); end
      checks++; if (bsy[i] !== 1'b0) begin errors++; $display("FAIL areset_busy[%0d]: got %b want 0", i, bsy[i]); end
      checks++; if (pc[i] !== 2'd0) begin errors++; $display("FAIL areset_pend[%0d]: got %0d want 0", i, pc[i]); end
    end
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    for (int j = 0; j < 10; j++) begin
      cycle(1'b0, 1'b0);
      checks++; if (lvl[0] !== 1'b0 || bsy[0] !== 1'b0) begin
        errors++; $display("FAIL areset_resume j=%0d: got level=%b busy=%b want 0", j, lvl[0], bsy[0]);
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      int dens;
      dens = (n < 300) ? 30 : 70;
      cycle($urandom_range(0, 99) < dens, $urandom_range(0, 99) < 5);
      for (int i = 0; i < N; i++) begin
        bit el, eb;
        el = (hi_left[i] > 0);
        eb = (hi_left[i] > 0) || (gap_left[i] > 0);
        checks++; if (lvl[i] !== el) begin errors++; $display("FAIL rand_level[%0d] n=%0d: got %b want %b", i, n, lvl[i], el); end
        checks++; if (bsy[i] !== eb) begin errors++; $display("FAIL rand_busy[%0d] n=%0d: got %b want %b", i, n, bsy[i], eb); end
        checks++; if (int'(pc[i]) != m_pend[i]) begin errors++; $display("FAIL rand_pend[%0d] n=%0d: got %0d want %0d", i, n, pc[i], m_pend[i]); end
        checks++; if (ovf[i] !== m_ovf[i]) begin errors++; $display("FAIL rand_ovf[%0d] n=%0d: got %b want %b", i, n, ovf[i], m_ovf[i]); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    drain();
    test_queue();
    drain();
    test_saturate();
    drain();
    test_retrigger();
    drain();
    test_gap0();
    drain();
    test_async_reset();
    drain();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
